backscatter_scheduler: RTL and testbench

BACKSCATTER_SCHEDULER -- requirements
Module: backscatter_scheduler

---
 rtl/hh_pkg.sv | 8 +
 rtl/tag_shift_reg.sv | 49 ++++
 rtl/backscatter_scheduler.sv | 98 +++++++++
 tb/tb_backscatter_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hh_pkg.sv
// hh_pkg: shared state encoding and default timing for the backscatter scheduler.
package hh_pkg;
  typedef enum logic [1:0] {IDLE, GUARD, SEND, DRAIN} state_e;
  localparam int GUARD_CYCLES_DEF  = 448;
  localparam int BIT_CYCLES_DEF    = 50;
  localparam int WINDOW_CYCLES_DEF = 6000;
  localparam int WORD_W            = 16;
endpackage

// File: rtl/tag_shift_reg.sv
// tag_shift_reg: tag word holding register, remaining-bit count and word handshake.
module tag_shift_reg
  import hh_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              pop_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              bit_o,
  output logic              starve_o
);
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [4:0]        rem_q, rem_d;
  logic              xfer;
  assign ready_o  = en_i && rem_q == 5'd0;
  assign xfer     = valid_i && ready_o;
  assign starve_o = rem_q == 5'd0 && !xfer;
  // a word arriving on the popping edge supplies the bit directly, so there is no gap
  assign bit_o    = xfer ? word_i[WORD_W-1] : sr_q[WORD_W-1];
  always_comb begin
    sr_d  = sr_q;
    rem_d = rem_q;
    if (clr_i) begin
      sr_d  = '0;
      rem_d = '0;
    end else if (pop_i && xfer) begin
      sr_d  = {word_i[WORD_W-2:0], 1'b0};
      rem_d = 5'd15;
    end else if (pop_i && rem_q != 5'd0) begin
      sr_d  = {sr_q[WORD_W-2:0], 1'b0};
      rem_d = rem_q - 5'd1;
    end else if (xfer) begin
      sr_d  = word_i;
      rem_d = 5'd16;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr_q  <= '0;
      rem_q <= '0;
    end else begin
      sr_q  <= sr_d;
      rem_q <= rem_d;
    end
endmodule

// File: rtl/backscatter_scheduler.sv
// backscatter_scheduler: times tag bits inside an excitation packet window.
// BACKSCATTER_PAD_EN: pad with zero bits on underrun instead of draining.
module backscatter_scheduler
  import hh_pkg::*;
#(
  parameter int GUARD_CYCLES  = GUARD_CYCLES_DEF,
  parameter int BIT_CYCLES    = BIT_CYCLES_DEF,
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        trigger_signal,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        output_signal,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] pkt_count,
  output logic [15:0] bits_sent
);
`ifdef BACKSCATTER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  state_e      state_q, state_d;
  logic [1:0]  sync_q, live_q;
  logic        trig_prev_q, armed_q, armed_d, out_q, out_d, und_q, und_d;
  logic [15:0] elapsed_q, elapsed_d, bit_cnt_q, bit_cnt_d, pkt_q, pkt_d, bits_q, bits_d;
  logic        trig_s, rise, fall, guard_done, boundary, win_end, pop, pop_bit, starve, starve_ev;
  assign trig_s = sync_q[1];
  // a rise only counts once a genuine low has been seen after reset release
  assign armed_d    = armed_q || (live_q[1] && !trig_s);
  assign rise       = armed_q && trig_s && !trig_prev_q;
  assign fall       = trig_prev_q && !trig_s;
  assign guard_done = state_q == GUARD && elapsed_q == 16'(GUARD_CYCLES - 1);
  assign boundary   = state_q == SEND && bit_cnt_q == 16'(BIT_CYCLES - 1);
  assign win_end    = state_q == SEND && elapsed_q == 16'(WINDOW_CYCLES - 1);
  assign pop        = !fall && (guard_done || (boundary && !win_end));
  assign starve_ev  = pop && starve;
  always_comb begin
    state_d = state_q;
    if (fall) state_d = IDLE;
    else if (state_q == IDLE && rise) state_d = GUARD;
    else if (guard_done || win_end || (state_q == SEND && boundary))
      state_d = (win_end || (starve_ev && !PAD_EN)) ? DRAIN : SEND;
    elapsed_d = rise ? 16'd0 : (state_q != IDLE && elapsed_q != 16'hFFFF) ? elapsed_q + 16'd1 : elapsed_q;
    bit_cnt_d = pop ? 16'd0 : (state_q == SEND) ? bit_cnt_q + 16'd1 : bit_cnt_q;
    pkt_d     = pkt_q + 16'(state_q == GUARD && state_d == SEND);
    bits_d    = rise ? 16'd0 : bits_q + 16'(pop && state_q == SEND);
    und_d     = und_q || starve_ev;
    out_d     = (state_d == SEND) ? (pop ? pop_bit : out_q) : 1'b0;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      live_q      <= '0;
      trig_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      elapsed_q   <= '0;
      bit_cnt_q   <= '0;
      pkt_q       <= '0;
      bits_q      <= '0;
      und_q       <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], trigger_signal};
      live_q      <= {live_q[0], 1'b1};
      trig_prev_q <= trig_s;
      armed_q     <= armed_d;
      elapsed_q   <= elapsed_d;
      bit_cnt_q   <= bit_cnt_d;
      pkt_q       <= pkt_d;
      bits_q      <= bits_d;
      und_q       <= und_d;
      out_q       <= out_d;
    end
  tag_shift_reg u_tsr (
    .clk     (clock),
    .rst_n   (reset),
    .clr_i   (fall),
    .en_i    (state_q == GUARD || state_q == SEND),
    .pop_i   (pop),
    .word_i  (word_in),
    .valid_i (word_valid),
    .ready_o (word_ready),
    .bit_o   (pop_bit),
    .starve_o(starve)
  );
  assign output_signal = out_q;
  assign busy          = state_q != IDLE;
  assign underrun      = und_q;
  assign pkt_count     = pkt_q;
  assign bits_sent     = bits_q;
endmodule

// File: tb/tb_backscatter_scheduler.sv
// tb_backscatter_scheduler: directed checks of guard, bit timing, window, underrun and reset.
module tb_backscatter_scheduler;
  logic        clock = 1'b0, reset = 1'b0, trigger_signal = 1'b0, word_valid = 1'b0;
  logic [15:0] word_in = '0;
  logic        word_ready, output_signal, busy, underrun;
  logic [15:0] pkt_count, bits_sent;
  int          n, errors, checks;
  logic [15:0] q[$];
  logic [15:0] w;

  backscatter_scheduler dut (
    .clock(clock), .reset(reset), .trigger_signal(trigger_signal),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .output_signal(output_signal), .busy(busy), .underrun(underrun),
    .pkt_count(pkt_count), .bits_sent(bits_sent)
  );

  always #5 clock = ~clock;

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @n=%0d: observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @n=%0d: observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic drive();
    word_valid = q.size() > 0;
    word_in    = word_valid ? q[0] : 16'h0;
  endtask

  task automatic tick();
    bit acc;
    acc = word_valid && word_ready;
    @(posedge clock);
    #1;
    n++;
    if (acc && q.size() > 0) void'(q.pop_front());
    drive();
  endtask

  task automatic run_to(int t);
    while (n < t) tick();
  endtask

  task automatic do_reset();
    q.delete();
    drive();
    trigger_signal = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
  endtask

  task automatic start();
    n = 0;
    trigger_signal = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    n = 0;
    do_reset();
    chk1("rst_out", output_signal, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_und", underrun, 1'b0);
    chk1("rst_ready", word_ready, 1'b0);
    chk16("rst_pkt", pkt_count, 16'd0);
    chk16("rst_bits", bits_sent, 16'd0);

    // single word 0xA5A5, trigger held for 8000 cycles
    q.push_back(16'hA5A5); drive(); start();
    run_to(2);    chk1("a5_idle_busy", busy, 1'b0);
    run_to(3);    chk1("a5_guard_busy", busy, 1'b1); chk1("a5_ready", word_ready, 1'b1);
    run_to(4);    chk1("a5_ready_taken", word_ready, 1'b0);
    run_to(450);  chk1("a5_guard_out", output_signal, 1'b0); chk16("a5_pkt0", pkt_count, 16'd0);
    run_to(451);  chk1("a5_first_bit", output_signal, 1'b1); chk16("a5_pkt1", pkt_count, 16'd1);
    w = 16'hA5A5;
    for (int k = 0; k < 16; k++) begin
      run_to(451 + 50 * k + 25);
      chk1("a5_bit", output_signal, w[15-k]);
    end
    run_to(1250); chk1("a5_last_bit", output_signal, 1'b1); chk1("a5_und0", underrun, 1'b0);
    chk16("a5_bits15", bits_sent, 16'd15);
    run_to(1251); chk1("a5_und1", underrun, 1'b1); chk16("a5_bits16", bits_sent, 16'd16);
    chk1("a5_out_drain", output_signal, 1'b0); chk1("a5_busy_drain", busy, 1'b1);
    run_to(8000); chk1("a5_busy_8000", busy, 1'b1); chk1("a5_out_8000", output_signal, 1'b0);
    trigger_signal = 1'b0;
    run_to(8002); chk1("a5_busy_fall2", busy, 1'b1);
    run_to(8003); chk1("a5_idle", busy, 1'b0); chk16("a5_bits_keep", bits_sent, 16'd16);
    chk1("a5_und_sticky", underrun, 1'b1); chk16("a5_pkt_keep", pkt_count, 16'd1);

    // back-to-back words 0xFFFF then 0x0000
    do_reset();
    q.push_back(16'hFFFF); q.push_back(16'h0000); drive(); start();
    for (int k = 0; k < 15; k++) begin
      run_to(451 + 50 * k + 25);
      chk1("b2b_bit", output_signal, 1'b1);
    end
    run_to(1201); chk1("b2b_ready_hi", word_ready, 1'b1);
    run_to(1202); chk1("b2b_ready_lo", word_ready, 1'b0);
    for (int k = 15; k < 32; k++) begin
      if (k == 16) begin
        run_to(1251);
        chk1("b2b_no_gap_und", underrun, 1'b0); chk16("b2b_bits16", bits_sent, 16'd16);
        chk1("b2b_no_gap_busy", busy, 1'b1);
      end
      run_to(451 + 50 * k + 25);
      chk1("b2b_bit", output_signal, k < 16);
    end
    run_to(2050); chk1("b2b_und0", underrun, 1'b0); chk16("b2b_bits31", bits_sent, 16'd31);
    run_to(2051); chk1("b2b_und1", underrun, 1'b1); chk16("b2b_bits32", bits_sent, 16'd32);
    trigger_signal = 1'b0;
    run_to(2054); chk1("b2b_idle", busy, 1'b0);

    // trigger falls at cycle 1000 mid-bit
    do_reset();
    q.push_back(16'hFFFF); drive(); start();
    run_to(1000); trigger_signal = 1'b0;
    run_to(1002); chk1("fall_out_hold", output_signal, 1'b1); chk1("fall_busy_hold", busy, 1'b1);
    run_to(1003); chk1("fall_out0", output_signal, 1'b0); chk1("fall_idle", busy, 1'b0);
    chk16("fall_bits11", bits_sent, 16'd11);
    run_to(1100); chk16("fall_bits_keep", bits_sent, 16'd11); chk1("fall_ready", word_ready, 1'b0);

    // window expiry with continuous words
    do_reset();
    for (int k = 0; k < 10; k++) q.push_back(16'hFFFF);
    drive(); start();
    run_to(6002); chk1("win_out_last", output_signal, 1'b1); chk16("win_bits_pre", bits_sent, 16'd111);
    run_to(6003); chk1("win_out0", output_signal, 1'b0); chk16("win_bits111", bits_sent, 16'd111);
    chk1("win_busy", busy, 1'b1); chk1("win_ready", word_ready, 1'b0); chk1("win_und", underrun, 1'b0);
    run_to(6500); chk1("win_drain_busy", busy, 1'b1); chk16("win_bits_keep", bits_sent, 16'd111);
    trigger_signal = 1'b0;
    run_to(6503); chk1("win_idle", busy, 1'b0);

    // no word at guard exit
    do_reset();
    start();
    run_to(450); chk1("nw_und0", underrun, 1'b0);
    run_to(451); chk1("nw_und1", underrun, 1'b1); chk1("nw_out", output_signal, 1'b0);
    chk1("nw_busy", busy, 1'b1);
    run_to(460); q.push_back(16'hFFFF); drive();
`ifdef BACKSCATTER_PAD_EN
    chk16("nw_pkt_pad", pkt_count, 16'd1);
    run_to(500); chk1("nw_pad_zero", output_signal, 1'b0);
    run_to(501); chk1("nw_pad_resume", output_signal, 1'b1); chk16("nw_pad_bits", bits_sent, 16'd1);
`else
    chk16("nw_pkt_drain", pkt_count, 16'd0);
    run_to(501); chk1("nw_drain_out", output_signal, 1'b0); chk16("nw_drain_bits", bits_sent, 16'd0);
    chk1("nw_drain_ready", word_ready, 1'b0);
`endif
    trigger_signal = 1'b0;
    run_to(504); chk1("nw_idle", busy, 1'b0);

    // reset pulsed mid-SEND
    do_reset();
    q.push_back(16'hFFFF); drive(); start();
    run_to(700); chk1("rs_out_pre", output_signal, 1'b1); chk1("rs_busy_pre", busy, 1'b1);
    #3 reset = 1'b0;
    #1;
    chk1("rs_out", output_signal, 1'b0); chk1("rs_busy", busy, 1'b0);
    chk16("rs_pkt", pkt_count, 16'd0); chk16("rs_bits", bits_sent, 16'd0);
    chk1("rs_ready", word_ready, 1'b0); chk1("rs_und", underrun, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (600) tick();
    chk1("rs_quiet_busy", busy, 1'b0); chk1("rs_quiet_out", output_signal, 1'b0);
    chk16("rs_quiet_pkt", pkt_count, 16'd0);
    trigger_signal = 1'b0;
    repeat (5) tick();
    start();
    run_to(2); chk1("rs_rise_busy0", busy, 1'b0);
    run_to(3); chk1("rs_rise_busy1", busy, 1'b1);
    trigger_signal = 1'b0;
    run_to(6); chk1("rs_end_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
